traffic_light_rx: RTL
=====================

Name: traffic_light_rx

Overview:
- Receiving end of the traffic-light FSM interface. Consumes the light level, lane select, valid pulses and remaining-time values, and rebuilds the phase locally.
- Drives per-lane go/warn outputs for the VGA road renderer.
- Holds a saturating waiting-car queue per lane and releases one car at a time during green.
- Flags protocol violations with a sticky error bit.

Parameters:
- WARN_SEC, 3, green time remaining (s) at or below which the active lane enters WARN.
- GAP_SEC, 2, tick_sec pulses between successive car releases.
- MAX_Q, 15, queue saturation value per lane.
- Q_W, 4, queue counter width; must satisfy MAX_Q < 2^Q_W.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- tick_sec  in  1  one-cycle 1 s strobe
- tr_light  in  1  light level: 1 = green, 0 = red
- tr_state  in  1  active lane of the new cycle: 0 = NS, 1 = EW
- tr_valid  in  1  one-cycle pulse: new cycle start, tr_state valid
- light_valid  in  1  one-cycle pulse: phase change
- green_left_time  in  5  remaining green seconds
- car_arrive  in  2  per-lane one-cycle arrival pulse
- lane_go  out  2  per-lane go level
- lane_warn  out  2  per-lane warning (yellow) level
- car_release  out  2  per-lane one-cycle release pulse
- q_count0  out  Q_W  lane 0 queue depth
- q_count1  out  Q_W  lane 1 queue depth
- active_lane  out  1  latched lane
- phase  out  2  0 = IDLE, 1 = RED, 2 = GREEN, 3 = WARN
- proto_err  out  1  sticky protocol error
- q_ovf  out  1  sticky queue overflow

Behaviour:
- Reset: all outputs 0; phase IDLE; queues 0; gap counter 0.
- All outputs are registered. Each reacts one clk after its cause.
- Cycle start: tr_valid=1 and light_valid=1 in the same cycle. From any phase, go to RED and latch active_lane <= tr_state.
- RED -> GREEN: light_valid=1 and tr_valid=0 while in RED.
- GREEN -> WARN: green_left_time <= WARN_SEC. Checked every cycle while in GREEN.
- Phase change: light_valid alone while in IDLE, GREEN or WARN sets proto_err and leaves phase unchanged.
- tr_valid without light_valid: sets proto_err and is otherwise ignored.
- Light mismatch: tr_light disagrees with the phase for 2 or more consecutive cycles → set proto_err.
  - RED expects tr_light=0; GREEN and WARN expect 1; IDLE is not checked.
  - A single-cycle mismatch is legal: the upstream valids lag its light level by one clk.
- proto_err and q_ovf are cleared only by reset.
- lane_go[active_lane]=1 only in GREEN.
- lane_warn[active_lane]=1 only in WARN.
- The non-active lane always has go=0 and warn=0.
- Queues: car_arrive[i] increments queue i.
  - Arrival at MAX_Q is dropped and sets q_ovf.
  - Arrivals on both lanes in the same cycle are both handled.
- Release, GREEN only, active lane only:
  - On GREEN entry the gap counter is loaded with 0, so the first release is eligible immediately.
  - When the gap counter is 0 and the queue is > 0: pulse car_release for one cycle, decrement the queue, load the gap counter with GAP_SEC.
  - The gap counter decrements on tick_sec and saturates at 0.
- Arrival and release on the same lane in the same cycle: queue unchanged. An arrival at MAX_Q is not dropped when it coincides with a release.
- No release in RED, WARN or IDLE.
- Leaving GREEN freezes the gap counter; it reloads at the next GREEN entry.
- A reset asserted mid-operation clears everything, including queues, asynchronously.

Test Plan:
- Basic cycle:
  - tr_valid+light_valid with tr_state=1 -> next clk: phase=1, active_lane=1, lane_go=00.
  - light_valid alone -> phase=2, lane_go=10.
  - green_left_time=3 -> phase=3, lane_warn=10, lane_go=00.
- Queue release:
  - Preconditions: lane 0 queue=3, enter GREEN on lane 0, GAP_SEC=2.
  - Required: car_release[0] pulses at entry+1 clk, then 2 ticks later, then 2 ticks after that; q_count0 = 2, 1, 0; no further pulses.
- Saturation: 16 arrivals on lane 1 in RED -> q_count1=15, q_ovf=1, no releases.
- Simultaneous events:
  - GREEN lane 0, queue 5, gap 0, car_arrive=01 in the same cycle as the release -> q_count0 stays 5.
  - car_arrive=11 in RED -> both queues increment.
- Protocol errors:
  - light_valid alone in GREEN -> proto_err=1, phase stays 2.
  - Separately, tr_light=0 held 2 cycles in GREEN -> proto_err=1.
  - A 1-cycle glitch -> proto_err stays 0.
- Reset mid-GREEN with queue 4 -> all outputs 0, phase=0.
  - After release, light_valid alone -> proto_err=1.
  - After release, a cycle start -> RED.

Source files
------------

// File: rtl/traffic_light_rx.sv
// Receiver for the traffic-light FSM link: rebuilds the light phase locally, drives
// per-lane go/warn levels, and meters a waiting-car queue per lane during green.
module traffic_light_rx #(
    parameter int unsigned WARN_SEC = 3,
    parameter int unsigned GAP_SEC  = 2,
    parameter int unsigned MAX_Q    = 15,
    parameter int unsigned Q_W      = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tick_sec,
    input  logic           tr_light,
    input  logic           tr_state,
    input  logic           tr_valid,
    input  logic           light_valid,
    input  logic [4:0]     green_left_time,
    input  logic [1:0]     car_arrive,
    output logic [1:0]     lane_go,
    output logic [1:0]     lane_warn,
    output logic [1:0]     car_release,
    output logic [Q_W-1:0] q_count0,
    output logic [Q_W-1:0] q_count1,
    output logic           active_lane,
    output logic [1:0]     phase,
    output logic           proto_err,
    output logic           q_ovf
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRed   = 2'd1,
        StGreen = 2'd2,
        StWarn  = 2'd3
    } phase_e;

    localparam int unsigned    G_W      = (GAP_SEC < 2) ? 1 : $clog2(GAP_SEC + 1);
    localparam logic [G_W-1:0] GAP_LOAD = G_W'(GAP_SEC);
    localparam logic [Q_W-1:0] Q_MAX    = Q_W'(MAX_Q);
    localparam logic [4:0]     WARN_T   = 5'(WARN_SEC);

    phase_e                  phase_q, phase_d;
    logic                    lane_q, lane_d;
    logic                    err_d, ovf_d;
    logic                    mm_q, mismatch;
    logic [G_W-1:0]          gap_q, gap_d;
    logic [1:0][Q_W-1:0]     q_q, q_d;
    logic [1:0]              rel_d;

    // Phase tracking and protocol checking.
    always_comb begin
        phase_d  = phase_q;
        lane_d   = lane_q;
        err_d    = proto_err;
        mismatch = 1'b0;
        case (phase_q)
            StRed:          mismatch = tr_light;
            StGreen, StWarn: mismatch = ~tr_light;
            default:        mismatch = 1'b0;
        endcase
        // One-cycle disagreement is expected: the valids trail the light level.
        if (mismatch && mm_q) begin
            err_d = 1'b1;
        end
        if (tr_valid && light_valid) begin
            phase_d = StRed;
            lane_d  = tr_state;
        end else if (light_valid) begin
            if (phase_q == StRed) begin
                phase_d = StGreen;
            end else begin
                err_d = 1'b1;
            end
        end else if (tr_valid) begin
            err_d = 1'b1;
        end else if (phase_q == StGreen && green_left_time <= WARN_T) begin
            phase_d = StWarn;
        end
    end

    // Queue accounting and paced release on the active lane.
    always_comb begin
        rel_d = 2'b00;
        if (phase_q == StGreen && gap_q == '0 && q_q[lane_q] != '0) begin
            rel_d[lane_q] = 1'b1;
        end
        q_d   = q_q;
        ovf_d = q_ovf;
        for (int i = 0; i < 2; i++) begin
            if (car_arrive[i] && !rel_d[i]) begin
                if (q_q[i] == Q_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    q_d[i] = q_q[i] + Q_W'(1);
                end
            end else if (!car_arrive[i] && rel_d[i]) begin
                q_d[i] = q_q[i] - Q_W'(1);
            end
        end
        gap_d = gap_q;
        if (phase_d == StGreen && phase_q != StGreen) begin
            gap_d = '0;
        end else if (rel_d != 2'b00) begin
            gap_d = GAP_LOAD;
        end else if (phase_q == StGreen && tick_sec && gap_q != '0) begin
            gap_d = gap_q - G_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q     <= StIdle;
            lane_q      <= 1'b0;
            mm_q        <= 1'b0;
            gap_q       <= '0;
            q_q         <= '0;
            proto_err   <= 1'b0;
            q_ovf       <= 1'b0;
            car_release <= 2'b00;
            lane_go     <= 2'b00;
            lane_warn   <= 2'b00;
        end else begin
            phase_q     <= phase_d;
            lane_q      <= lane_d;
            mm_q        <= mismatch;
            gap_q       <= gap_d;
            q_q         <= q_d;
            proto_err   <= err_d;
            q_ovf       <= ovf_d;
            car_release <= rel_d;
            lane_go     <= (phase_d == StGreen) ? (lane_d ? 2'b10 : 2'b01) : 2'b00;
            lane_warn   <= (phase_d == StWarn)  ? (lane_d ? 2'b10 : 2'b01) : 2'b00;
        end
    end

    assign phase       = phase_q;
    assign active_lane = lane_q;
    assign q_count0    = q_q[0];
    assign q_count1    = q_q[1];

endmodule
